sd_request_arbiter: RTL and testbench
=====================================

Name: sd_request_arbiter

Overview:
Shares the single SD sector engine (the 6-bit rstart/wstart, rsector, rbusy, rdone and sector-data interface of sd_card) between up to six core requesters, e.g. 2x floppy and 2x ACSI images. It latches per-requester read and write requests and grants them round-robin, one transaction at a time. It drives a one-hot start with the granted sector, and routes done, busy and data strobes back to the winner only. It also enforces an idle gap between transactions so sd_card's edge-triggered MCU irq fires for every request, and it aborts transactions that never complete.

Parameters:
N, 6, number of requesters; legal range 1..6.
GAP_CYCLES, 2, cycles with all starts low between two transactions; minimum 1.
TIMEOUT, 32'd50_000_000, cycles in WAIT before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
req_rd  in  N  per-requester read request; sampled every cycle
req_wr  in  N  per-requester write request; sampled every cycle
req_sector  in  32*N  sector of requester i in bits [32i+31:32i]; held stable from request until req_done
req_inbyte  in  8*N  write data of requester i in bits [8i+7:8i]
req_busy  out  N  requester i pending or active
req_done  out  N  1-cycle completion pulse
req_err  out  N  1-cycle timeout pulse; coincides with req_done
req_outen  out  N  sd_outen gated to the granted requester
sd_rstart  out  6  to sd_card rstart
sd_wstart  out  6  to sd_card wstart
sd_rsector  out  32  to sd_card rsector
sd_inbyte  out  8  to sd_card inbyte
sd_rbusy  in  1  from sd_card (informational only; not used for sequencing)
sd_rdone  in  1  from sd_card; completion pulse
sd_outen  in  1  from sd_card

Behaviour:
- Reset (rstn=0 at a clk edge):
  - All outputs 0, pend_rd/pend_wr cleared, state IDLE, last_grant=N-1, counters 0.
  - A reset mid-transaction drops the starts immediately; no req_done is issued.
- Request latching: each cycle, for every i, pend_rd[i] |= req_rd[i] and pend_wr[i] |= req_wr[i]. Repeated requests while pending are absorbed. Requests are level or pulse; one cycle high is sufficient.
- req_busy[i] = pend_rd[i] | pend_wr[i] | (state!=IDLE && state!=GAP && grant==i).
- IDLE:
  - If any pending bit is set, pick the first i with pending bit set, scanning from last_grant+1 modulo N.
  - Transaction type: read if pend_rd[i], else write.
  - Register grant=i and is_wr, and register sd_rsector=req_sector[i].
  - Clear the serviced pending bit. Next state ISSUE.
- ISSUE (1 cycle): assert sd_rstart[grant] (or sd_wstart[grant]) as one-hot. Clear the timeout counter. Next state WAIT.
- WAIT:
  - Hold the start bit and sd_rsector. The timeout counter increments each cycle.
  - On sd_rdone=1: drop the start, pulse req_done[grant], last_grant<=grant, go to GAP.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 without sd_rdone: do the same and additionally pulse req_err[grant].
  - If sd_rdone and the timeout coincide, it is a normal completion and req_err stays 0.
- GAP: all starts low for GAP_CYCLES cycles, then IDLE. The next grant is therefore at the earliest GAP_CYCLES+1 cycles after done.
- Latency: the start is visible 2 cycles after a request edge from IDLE (latch, then grant/ISSUE).
- Simultaneous read and write from the same i: the read is serviced first. The write stays pending and gets its own later grant; the round-robin pointer still advances.
- A new request from the active requester during WAIT or GAP re-arms its pending bit, which is serviced on a later grant.
- Datapath:
  - sd_inbyte = req_inbyte[grant] (combinational).
  - req_outen[i] = sd_outen & (state==WAIT) & !is_wr & (grant==i).
  - Requesters take outaddr/outbyte directly from sd_card.
- Out-of-range bits: sd_rstart/sd_wstart bits >= N are tied 0. req_* bits for unused indices do not exist.
- At most one bit of sd_rstart|sd_wstart is high at any time. The bench asserts this invariant.

Test Plan:
1. Single read: req_rd[2] pulses 1 cycle with sector 0x0000_1234. Expected: 2 cycles later sd_rstart=6'b000100 and sd_rsector=0x1234. After sd_rdone, req_done[2] pulses once; starts are low for 2 cycles.
2. Round-robin: req_rd = 6'b100011 in the same cycle. Expected grant order 0, 1, 5. Repeating with last_grant=0 gives order 1, 5, 0.
3. Read plus write on requester 3 in the same cycle. Expected: sd_rstart[3] transaction, then a GAP, then a sd_wstart[3] transaction. sd_inbyte follows req_inbyte[3]; req_outen[3] is high only during the read.
4. Timeout with TIMEOUT=100 and sd_rdone never arriving. Expected: start drops on cycle 100 of WAIT, req_done[1] and req_err[1] pulse together, and the next pending request is granted.
5. Reset mid-WAIT: rstn=0 for 1 cycle. Expected: next cycle all starts are 0, req_busy=0, and there is no req_done. A later request is serviced normally.
6. Re-request during WAIT: req_rd[4] again before sd_rdone. Expected: req_done[4], then GAP, then a second grant to 4 with a fresh sd_rsector sample.

Source files
------------

// File: rtl/sd_request_arbiter_if.sv
// Signal bundle between the requester cores, the sector-engine arbiter and sd_card.
// The master view belongs to the arbiter; the slave view belongs to the surrounding system.
interface sd_request_arbiter_if #(
    parameter int N = 6
);
    logic [N-1:0]    req_rd;
    logic [N-1:0]    req_wr;
    logic [32*N-1:0] req_sector;
    logic [8*N-1:0]  req_inbyte;
    logic [N-1:0]    req_busy;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_err;
    logic [N-1:0]    req_outen;
    logic [5:0]      sd_rstart;
    logic [5:0]      sd_wstart;
    logic [31:0]     sd_rsector;
    logic [7:0]      sd_inbyte;
    logic            sd_rbusy;
    logic            sd_rdone;
    logic            sd_outen;

    modport master (
        input  req_rd, req_wr, req_sector, req_inbyte, sd_rbusy, sd_rdone, sd_outen,
        output req_busy, req_done, req_err, req_outen,
               sd_rstart, sd_wstart, sd_rsector, sd_inbyte
    );

    modport slave (
        output req_rd, req_wr, req_sector, req_inbyte, sd_rbusy, sd_rdone, sd_outen,
        input  req_busy, req_done, req_err, req_outen,
               sd_rstart, sd_wstart, sd_rsector, sd_inbyte
    );
endinterface

// File: rtl/sd_request_arbiter.sv
// Round-robin arbiter sharing one sd_card sector engine between up to six requesters,
// with an enforced idle gap between transactions and an optional completion timeout.
module sd_request_arbiter #(
    parameter int          N          = 6,
    parameter int          GAP_CYCLES = 2,
    parameter logic [31:0] TIMEOUT    = 32'd50_000_000
) (
    input  logic                 clk,
    input  logic                 rstn,
    sd_request_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic          is_wr_q, is_wr_d;
    logic [2:0]    last_grant_q, last_grant_d;
    logic [N-1:0]  pend_rd_q, pend_rd_d;
    logic [N-1:0]  pend_wr_q, pend_wr_d;
    logic [5:0]    rstart_q, rstart_d;
    logic [5:0]    wstart_q, wstart_d;
    logic [31:0]   rsector_q, rsector_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [15:0]   gap_q, gap_d;
    logic [N-1:0]  done_q, done_d;
    logic [N-1:0]  err_q, err_d;
    logic [N-1:0]  busy_q, busy_d;

    logic [N-1:0]  pend_any_s;
    logic [N-1:0]  clr_rd_s;
    logic [N-1:0]  clr_wr_s;
    logic [N-1:0]  outen_s;
    logic [2:0]    idx_s;
    logic [2:0]    pick_s;
    logic          found_s;
    logic          finish_s;
    logic          timed_out_s;
    logic          unused_s;

    // sd_rbusy is informational; sequencing relies solely on sd_rdone
    assign unused_s = bus.sd_rbusy;

    // Round-robin scan: first pending requester after last_grant, wrapping modulo N
    always_comb begin
        pend_any_s = pend_rd_q | pend_wr_q;
        found_s    = 1'b0;
        pick_s     = 3'd0;
        idx_s      = 3'd0;
        for (int k = 1; k <= N; k++) begin
            idx_s = 3'((int'(last_grant_q) + k) % N);
            if (!found_s && pend_any_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Transaction FSM next-state, start/sector datapath and completion pulses
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        is_wr_d      = is_wr_q;
        last_grant_d = last_grant_q;
        rstart_d     = rstart_q;
        wstart_d     = wstart_q;
        rsector_d    = rsector_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        done_d       = '0;
        err_d        = '0;
        clr_rd_s     = '0;
        clr_wr_s     = '0;
        timed_out_s  = (TIMEOUT != 32'd0) && (tmo_q == TIMEOUT - 32'd1);
        finish_s     = bus.sd_rdone || timed_out_s;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d   = pick_s;
                    rsector_d = bus.req_sector[int'(pick_s)*32 +: 32];
                    // Reads win over a simultaneous write; the write keeps its pending bit
                    if (pend_rd_q[pick_s]) begin
                        is_wr_d          = 1'b0;
                        clr_rd_s[pick_s] = 1'b1;
                        rstart_d         = 6'd1 << pick_s;
                    end else begin
                        is_wr_d          = 1'b1;
                        clr_wr_s[pick_s] = 1'b1;
                        wstart_d         = 6'd1 << pick_s;
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = 32'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (finish_s) begin
                    rstart_d        = 6'd0;
                    wstart_d        = 6'd0;
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = !bus.sd_rdone;
                    last_grant_d    = grant_q;
                    gap_d           = 16'd0;
                    state_d         = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == 16'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                rstart_d = 6'd0;
                wstart_d = 6'd0;
                state_d  = ST_IDLE;
            end
        endcase

        // New requests are OR-ed in after clearing so a same-cycle re-request survives
        pend_rd_d = (pend_rd_q & ~clr_rd_s) | bus.req_rd;
        pend_wr_d = (pend_wr_q & ~clr_wr_s) | bus.req_wr;

        busy_d = pend_rd_d | pend_wr_d;
        if ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) begin
            busy_d[grant_d] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 3'd0;
            is_wr_q      <= 1'b0;
            last_grant_q <= 3'(N - 1);
            pend_rd_q    <= '0;
            pend_wr_q    <= '0;
            rstart_q     <= 6'd0;
            wstart_q     <= 6'd0;
            rsector_q    <= 32'd0;
            tmo_q        <= 32'd0;
            gap_q        <= 16'd0;
            done_q       <= '0;
            err_q        <= '0;
            busy_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            is_wr_q      <= is_wr_d;
            last_grant_q <= last_grant_d;
            pend_rd_q    <= pend_rd_d;
            pend_wr_q    <= pend_wr_d;
            rstart_q     <= rstart_d;
            wstart_q     <= wstart_d;
            rsector_q    <= rsector_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Read-data strobe steered only to the requester owning an active read
    always_comb begin
        outen_s = '0;
        if ((state_q == ST_WAIT) && !is_wr_q && bus.sd_outen) begin
            outen_s[grant_q] = 1'b1;
        end else begin
            outen_s = '0;
        end
    end

    assign bus.sd_rstart  = rstart_q;
    assign bus.sd_wstart  = wstart_q;
    assign bus.sd_rsector = rsector_q;
    assign bus.sd_inbyte  = bus.req_inbyte[int'(grant_q)*8 +: 8];
    assign bus.req_busy   = busy_q;
    assign bus.req_done   = done_q;
    assign bus.req_err    = err_q;
    assign bus.req_outen  = outen_s;

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Directed bench for sd_request_arbiter: single read, round-robin order, read+write on one
// requester, timeout abort, reset mid-transaction and re-request during a transaction.
module tb_sd_request_arbiter;
    localparam int N = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;

    sd_request_arbiter_if #(.N(N)) bus ();

    sd_request_arbiter #(.N(N), .GAP_CYCLES(2), .TIMEOUT(32'd100)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [5:0] starts();
        return bus.sd_rstart | bus.sd_wstart;
    endfunction

    task automatic wait_start(input string tag, output int cnt);
        cnt = 0;
        while ((starts() == 6'd0) && (cnt < 40)) begin
            step();
            cnt++;
        end
        check({tag, "_start_seen"}, 32'(cnt < 40), 32'd1);
    endtask

    task automatic pulse_done();
        bus.sd_rdone = 1'b1;
        step();
        bus.sd_rdone = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [5:0] er, input logic [5:0] ew,
                         input logic [31:0] es);
        int c;
        wait_start(tag, c);
        check({tag, "_rstart"}, 32'(bus.sd_rstart), 32'(er));
        check({tag, "_wstart"}, 32'(bus.sd_wstart), 32'(ew));
        check({tag, "_sector"}, bus.sd_rsector, es);
        step();
        pulse_done();
        check({tag, "_done"}, 32'(bus.req_done), 32'(er | ew));
        check({tag, "_err"}, 32'(bus.req_err), 32'd0);
    endtask

    // At most one start line may be high at any time
    always @(negedge clk) begin
        if (rstn) begin
            total++;
            assert ($onehot0(bus.sd_rstart | bus.sd_wstart)) else begin
                bad++;
                $error("FAIL onehot_start: observed=%b/%b expected=at most one bit",
                       bus.sd_rstart, bus.sd_wstart);
            end
        end
    end

    initial begin
        bus.req_rd     = '0;
        bus.req_wr     = '0;
        bus.req_sector = '0;
        bus.req_inbyte = '0;
        bus.sd_rbusy   = 1'b0;
        bus.sd_rdone   = 1'b0;
        bus.sd_outen   = 1'b0;
        step();
        step();
        check("rst_busy", 32'(bus.req_busy), 32'd0);
        check("rst_start", 32'(starts()), 32'd0);
        check("rst_done", 32'(bus.req_done), 32'd0);
        check("rst_sector", bus.sd_rsector, 32'd0);
        rstn = 1'b1;

        // 1: single read, two-cycle latency, single done pulse, gap
        bus.req_sector[2*32 +: 32] = 32'h0000_1234;
        bus.req_rd[2] = 1'b1;
        step();
        bus.req_rd = '0;
        check("t1_latch_nostart", 32'(starts()), 32'd0);
        check("t1_busy", 32'(bus.req_busy), 32'h04);
        step();
        check("t1_rstart", 32'(bus.sd_rstart), 32'h04);
        check("t1_sector", bus.sd_rsector, 32'h0000_1234);
        step();
        step();
        pulse_done();
        check("t1_done", 32'(bus.req_done), 32'h04);
        check("t1_gap0", 32'(starts()), 32'd0);
        check("t1_busy_clr", 32'(bus.req_busy), 32'd0);
        step();
        check("t1_done_once", 32'(bus.req_done), 32'd0);
        check("t1_gap1", 32'(starts()), 32'd0);

        // 2: round-robin from reset pointer, then from last_grant=0
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        bus.req_rd = 6'b100011;
        step();
        bus.req_rd = '0;
        wait_start("t2a", n);
        check("t2a_rstart0", 32'(bus.sd_rstart), 32'h01);
        check("t2a_busy", 32'(bus.req_busy), 32'h23);
        step();
        pulse_done();
        check("t2a_done0", 32'(bus.req_done), 32'h01);
        wait_start("t2a_gap", n);
        check("t2a_gap_len", 32'(n), 32'd3);
        check("t2a_rstart1", 32'(bus.sd_rstart), 32'h02);
        step();
        pulse_done();
        check("t2a_done1", 32'(bus.req_done), 32'h02);
        serve("t2a_5", 6'b100000, 6'd0, 32'd0);
        bus.req_rd[0] = 1'b1;
        step();
        bus.req_rd = '0;
        serve("t2b_pre0", 6'b000001, 6'd0, 32'd0);
        bus.req_rd = 6'b100011;
        step();
        bus.req_rd = '0;
        serve("t2b_1", 6'b000010, 6'd0, 32'd0);
        serve("t2b_5", 6'b100000, 6'd0, 32'd0);
        serve("t2b_0", 6'b000001, 6'd0, 32'd0);

        // 3: read and write on requester 3 together; read first, outen only for the read
        bus.req_inbyte[3*8 +: 8] = 8'hA5;
        bus.req_sector[3*32 +: 32] = 32'h0000_0333;
        bus.sd_outen = 1'b1;
        bus.req_rd[3] = 1'b1;
        bus.req_wr[3] = 1'b1;
        step();
        bus.req_rd = '0;
        bus.req_wr = '0;
        wait_start("t3r", n);
        check("t3_rstart", 32'(bus.sd_rstart), 32'h08);
        check("t3_wstart_lo", 32'(bus.sd_wstart), 32'd0);
        check("t3_outen_issue", 32'(bus.req_outen), 32'd0);
        step();
        check("t3_outen_rd", 32'(bus.req_outen), 32'h08);
        check("t3_inbyte_rd", 32'(bus.sd_inbyte), 32'hA5);
        pulse_done();
        check("t3_done_rd", 32'(bus.req_done), 32'h08);
        check("t3_outen_gap", 32'(bus.req_outen), 32'd0);
        wait_start("t3w", n);
        check("t3_wstart", 32'(bus.sd_wstart), 32'h08);
        check("t3_rstart_lo", 32'(bus.sd_rstart), 32'd0);
        step();
        check("t3_outen_wr", 32'(bus.req_outen), 32'd0);
        check("t3_inbyte_wr", 32'(bus.sd_inbyte), 32'hA5);
        pulse_done();
        check("t3_done_wr", 32'(bus.req_done), 32'h08);
        bus.sd_outen = 1'b0;

        // 4: timeout on requester 1, then requester 2 with done coinciding with the timeout
        bus.req_rd[1] = 1'b1;
        bus.req_wr[2] = 1'b1;
        step();
        bus.req_rd = '0;
        bus.req_wr = '0;
        wait_start("t4", n);
        check("t4_rstart", 32'(bus.sd_rstart), 32'h02);
        n = 0;
        while ((starts() != 6'd0) && (n < 200)) begin
            step();
            n++;
        end
        check("t4_hold_cycles", 32'(n), 32'd101);
        check("t4_done", 32'(bus.req_done), 32'h02);
        check("t4_err", 32'(bus.req_err), 32'h02);
        wait_start("t4_next", n);
        check("t4_gap_len", 32'(n), 32'd3);
        check("t4_wstart", 32'(bus.sd_wstart), 32'h04);
        for (int i = 0; i < 100; i++) begin
            step();
        end
        check("t4b_still_wait", 32'(bus.sd_wstart), 32'h04);
        pulse_done();
        check("t4b_done", 32'(bus.req_done), 32'h04);
        check("t4b_err", 32'(bus.req_err), 32'd0);

        // 5: reset in WAIT drops everything without a done pulse
        bus.req_rd[0] = 1'b1;
        step();
        bus.req_rd = '0;
        wait_start("t5", n);
        check("t5_rstart", 32'(bus.sd_rstart), 32'h01);
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("t5_start_lo", 32'(starts()), 32'd0);
        check("t5_busy_lo", 32'(bus.req_busy), 32'd0);
        check("t5_no_done", 32'(bus.req_done), 32'd0);
        step();
        check("t5_no_done_later", 32'(bus.req_done), 32'd0);
        bus.req_sector[5*32 +: 32] = 32'hCAFE_0005;
        bus.req_rd[5] = 1'b1;
        step();
        bus.req_rd = '0;
        serve("t5_after", 6'b100000, 6'd0, 32'hCAFE_0005);

        // 6: re-request during WAIT earns a second grant with a freshly sampled sector
        bus.req_sector[4*32 +: 32] = 32'hAAAA_0004;
        bus.req_rd[4] = 1'b1;
        step();
        bus.req_rd = '0;
        wait_start("t6a", n);
        check("t6a_rstart", 32'(bus.sd_rstart), 32'h10);
        check("t6a_sector", bus.sd_rsector, 32'hAAAA_0004);
        step();
        bus.req_rd[4] = 1'b1;
        step();
        bus.req_rd = '0;
        pulse_done();
        check("t6a_done", 32'(bus.req_done), 32'h10);
        check("t6a_busy_rearm", 32'(bus.req_busy), 32'h10);
        bus.req_sector[4*32 +: 32] = 32'h5555_0004;
        serve("t6b", 6'b010000, 6'd0, 32'h5555_0004);
        step();
        check("t6_busy_final", 32'(bus.req_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
